pci_initiator: RTL and testbench

Synthesizable PCI bus master that starts memory transactions toward one or more `Device` targets on the shared FRAME/IRDY/TRDY/DEVSEL/STOP/AD/CBE/PAR bus. A local client hands it a command, an address and a burst length. The block then runs the address phase and the data phases, follows target wait states, and handles the target terminations (disconnect with data, retry/disconnect without data). If no target claims the cycle, it performs a master abort. It replaces the behavioural initiator tasks used in benches, so targets can be exercised by real RTL.

---
 rtl/pci_initiator.sv | 184 ++++++++++++++++++
 tb/tb_pci_initiator.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_initiator.sv
// PCI bus master: runs one memory transaction (address phase plus up to MAX_WORDS data
// phases) for a local client. It follows target wait states, terminations and master abort.
module pci_initiator #(
  parameter int MAX_WORDS      = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic [31:0] wdata,
  output logic        wdata_rd,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [2:0]  count,
  output logic        FRAME,
  output logic        IRDY,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  inout  wire         PAR,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        STOP,
  output logic [2:0]  dbg_state
);

  // Client handshake: req is accepted only on an edge where busy=0. A req seen while busy
  // is dropped, not queued. wdata_rd=1 on an edge means the current wdata word was consumed.
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_STOPPING, S_END} state_t;

  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

  state_t        state, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   addr_q, addr_d;
  logic          is_write, is_write_d;
  logic [2:0]    remaining, remaining_d;
  logic [2:0]    count_d;
  logic [1:0]    status_d;
  logic [CW-1:0] dv_cnt, dv_cnt_d;
  logic          dv_seen, dv_seen_d;
  logic          capture;
  logic [2:0]    len_c;
  logic [31:0]   ad_o;
  logic          ad_oe;
  logic          par_q, par_oe;

  always_comb begin
    if (len == 3'd0)                len_c = 3'd1;
    else if (int'(len) > MAX_WORDS) len_c = 3'(MAX_WORDS);
    else                            len_c = len;
  end

  always_comb begin
    state_d     = state;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    is_write_d  = is_write;
    remaining_d = remaining;
    count_d     = count;
    status_d    = status;
    dv_cnt_d    = dv_cnt;
    dv_seen_d   = dv_seen;
    capture     = 1'b0;
    FRAME       = 1'b1;
    IRDY        = 1'b1;
    CBE         = 4'hF;
    ad_o        = addr_q;
    ad_oe       = 1'b0;
    wdata_rd    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_d     = S_ADDR;
          cmd_d       = cmd;
          addr_d      = addr;
          is_write_d  = cmd[0];
          remaining_d = len_c;
          count_d     = 3'd0;
          status_d    = 2'b00;
          dv_cnt_d    = '0;
          dv_seen_d   = 1'b0;
        end
      end
      S_ADDR: begin
        FRAME   = 1'b0;
        CBE     = cmd_q;
        ad_o    = addr_q;
        ad_oe   = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        IRDY     = 1'b0;
        CBE      = 4'h0;
        FRAME    = (remaining == 3'd1);
        ad_o     = wdata;
        ad_oe    = is_write;
        wdata_rd = is_write && !TRDY;
        if (!DEVSEL) dv_seen_d = 1'b1;
        if (!TRDY) begin
          count_d     = count + 3'd1;
          remaining_d = remaining - 3'd1;
          capture     = !is_write;
          if (STOP) begin
            if (remaining == 3'd1) begin
              status_d = 2'b00;
              state_d  = S_END;
            end
          end else begin
            status_d = (remaining == 3'd1) ? 2'b00 : 2'b01;
            state_d  = (remaining == 3'd1) ? S_END : S_STOPPING;
          end
        end else if (!STOP) begin
          status_d = 2'b10;
          state_d  = (remaining == 3'd1) ? S_END : S_STOPPING;
        end else if (DEVSEL && !dv_seen) begin
          // Nobody has claimed the cycle yet: count toward master abort.
          dv_cnt_d = dv_cnt + CW'(1);
          if (dv_cnt_d == CW'(DEVSEL_TIMEOUT)) begin
            status_d = 2'b11;
            state_d  = (remaining == 3'd1) ? S_END : S_STOPPING;
          end
        end
      end
      S_STOPPING: begin
        FRAME   = 1'b1;
        IRDY    = 1'b0;
        CBE     = 4'h0;
        ad_o    = wdata;
        ad_oe   = is_write;
        state_d = S_END;
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      cmd_q       <= 4'h0;
      addr_q      <= 32'h0;
      is_write    <= 1'b0;
      remaining   <= 3'd0;
      count       <= 3'd0;
      status      <= 2'b00;
      dv_cnt      <= '0;
      dv_seen     <= 1'b0;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      par_q       <= 1'b0;
      par_oe      <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      is_write    <= is_write_d;
      remaining   <= remaining_d;
      count       <= count_d;
      status      <= status_d;
      dv_cnt      <= dv_cnt_d;
      dv_seen     <= dv_seen_d;
      rdata_valid <= capture;
      if (capture) rdata <= AD;
      // Parity trails the phase it covers by one clock.
      par_q       <= ^{ad_o, CBE};
      par_oe      <= (state == S_ADDR) || (state == S_DATA && is_write);
    end
  end

  assign AD        = ad_oe ? ad_o : 32'bz;
  assign PAR       = par_oe ? par_q : 1'bz;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_END);
  assign dbg_state = state;

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: two behavioural targets on the bus, a write-data client and
// read/write scoreboards, plus one task per scenario.
module tb_pci_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  cmd = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [2:0]  len = 3'd0;
  logic [31:0] wdata = 32'h0;
  logic        wdata_rd;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [2:0]  count;
  logic        frame;
  logic        irdy;
  logic [3:0]  cbe;
  wire  [31:0] ad;
  wire         par;
  logic        trdy = 1'b1;
  logic        devsel = 1'b1;
  logic        stop = 1'b1;
  logic [2:0]  dbg_state;

  logic [31:0] t_ad = 32'h0;
  logic        t_ad_oe = 1'b0;
  assign ad = t_ad_oe ? t_ad : 32'bz;

  pci_initiator #(.MAX_WORDS(4), .DEVSEL_TIMEOUT(5)) dut (
    .CLK(clk), .RST(rst_n), .req(req), .cmd(cmd), .addr(addr), .len(len),
    .wdata(wdata), .wdata_rd(wdata_rd), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .status(status), .count(count),
    .FRAME(frame), .IRDY(irdy), .CBE(cbe), .AD(ad), .PAR(par),
    .TRDY(trdy), .DEVSEL(devsel), .STOP(stop), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_wq[$];
  logic [31:0] exp_rq[$];

  // ---------------- targets: 0xFFFF0000 (dev 0) and 0xFFFFF000 (dev 1) ----------------
  // Outputs are decided at the falling edge from the current bus phase and sampled by the
  // initiator at the next rising edge. Address offset 1 selects the terminating behaviour.
  logic [31:0] mem [32];
  logic        t_active = 1'b0;
  logic        t_claim = 1'b0;
  logic        t_first = 1'b0;
  logic [31:0] t_addr = 32'h0;
  logic [3:0]  t_cmd = 4'h0;
  logic [3:0]  t_idx = 4'h0;
  logic [4:0]  t_mi;
  logic [31:0] t_exp;

  always @(negedge clk) begin
    t_mi = {(t_addr[15:12] == 4'hF), t_addr[5:2] + t_idx};
    if (!t_active) begin
      t_ad_oe = 1'b0; trdy = 1'b1; devsel = 1'b1; stop = 1'b1;
      if (frame === 1'b0 && irdy === 1'b1) begin
        t_addr = ad; t_cmd = cbe; t_active = 1'b1; t_first = 1'b1; t_idx = 4'h0;
        t_claim = (t_addr[31:16] == 16'hFFFF) &&
                  (t_addr[15:12] == 4'h0 || t_addr[15:12] == 4'hF);
      end
    end else if (irdy === 1'b1) begin
      t_active = 1'b0; t_ad_oe = 1'b0; trdy = 1'b1; devsel = 1'b1; stop = 1'b1;
    end else if (t_claim) begin
      devsel = 1'b0;
      if (t_addr[1:0] == 2'b01) begin
        stop = 1'b0;
        trdy = t_cmd[0] ? 1'b0 : 1'b1;
      end else if (t_cmd[0]) begin
        trdy = 1'b0; stop = 1'b1;
        mem[t_mi] = ad;
        checks++;
        if (exp_wq.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: target got %h, none expected", ad);
        end else begin
          t_exp = exp_wq.pop_front();
          if (ad !== t_exp) begin
            errors++;
            $display("FAIL write_data: target got %h, expected %h", ad, t_exp);
          end
        end
        t_idx = t_idx + 4'd1;
      end else if (t_first) begin
        t_first = 1'b0; trdy = 1'b1; stop = 1'b1;
      end else begin
        t_ad = mem[t_mi]; t_ad_oe = 1'b1; trdy = 1'b0; stop = 1'b1;
        t_idx = t_idx + 4'd1;
      end
    end
  end

  // ---------------- write-data client ----------------
  logic [31:0] wbuf [8];
  int widx = 0;
  int n_wrd = 0;
  always @(posedge clk) begin
    if (wdata_rd === 1'b1) begin
      n_wrd++;
      #1;
      if (widx < 7) widx++;
      wdata = wbuf[widx];
    end
  end

  // ---------------- monitors / read scoreboard ----------------
  int n_rvalid = 0, n_done = 0, n_stop = 0, n_data = 0;
  logic prev_addr = 1'b0;
  logic par_aa = 1'b0;
  logic [31:0] r_exp;
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      n_rvalid++;
      checks++;
      if (exp_rq.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: rdata %h, none expected", rdata);
      end else begin
        r_exp = exp_rq.pop_front();
        if (rdata !== r_exp) begin
          errors++;
          $display("FAIL read_data: rdata %h, expected %h", rdata, r_exp);
        end
      end
    end
    if (done === 1'b1) n_done++;
    if (frame === 1'b1 && irdy === 1'b0) n_stop++;
    if (frame === 1'b0 && irdy === 1'b0) n_data++;
    if (prev_addr) par_aa = par;
    prev_addr = (frame === 1'b0 && irdy === 1'b1);
  end

  // ---------------- driver ----------------
  logic [1:0] st;
  logic [2:0] ct;

  task automatic clear_counts();
    n_wrd = 0; n_rvalid = 0; n_done = 0; n_stop = 0; n_data = 0;
    widx = 0; wdata = wbuf[0];
  endtask

  task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l);
    bit ok;
    clear_counts();
    cmd = c; addr = a; len = l; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    st = status; ct = count;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: no done for addr %h cmd %h", a, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    // used only for scalar status/counter observations
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if (frame !== 1'b1) begin errors++; $display("FAIL rst_frame: got %b expected 1", frame); end
    checks++;
    if (irdy !== 1'b1) begin errors++; $display("FAIL rst_irdy: got %b expected 1", irdy); end
    checks++;
    if (cbe !== 4'hF) begin errors++; $display("FAIL rst_cbe: got %h expected f", cbe); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_busy_done: got %b%b expected 00", busy, done);
    end
    checks++;
    if (status !== 2'b00 || count !== 3'd0) begin
      errors++; $display("FAIL rst_status_count: got %b/%0d expected 00/0", status, count);
    end
    checks++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rdata: got %h/%b expected 0/0", rdata, rdata_valid);
    end
    checks++;
  endtask

  task automatic test_write();
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'h0000F0F0 + 32'(i);
      exp_wq.push_back(32'h0000F0F0 + 32'(i));
    end
    run_txn(4'b0111, 32'hFFFF0000, 3'd4);
    if (st !== 2'b00) begin errors++; $display("FAIL wr_status: got %b expected 00", st); end
    checks++;
    if (ct !== 3'd4) begin errors++; $display("FAIL wr_count: got %0d expected 4", ct); end
    checks++;
    if (n_wrd !== 4) begin errors++; $display("FAIL wr_wdata_rd: got %0d expected 4", n_wrd); end
    checks++;
    if (par_aa !== 1'b1) begin errors++; $display("FAIL wr_addr_par: got %b expected 1", par_aa); end
    checks++;
    if (exp_wq.size() != 0) begin
      errors++; $display("FAIL wr_words_left: got %0d expected 0", exp_wq.size());
    end
    checks++;
  endtask

  task automatic test_read();
    for (int i = 0; i < 4; i++) exp_rq.push_back(32'h0000F0F0 + 32'(i));
    run_txn(4'b0110, 32'hFFFF0000, 3'd4);
    if (st !== 2'b00) begin errors++; $display("FAIL rd_status: got %b expected 00", st); end
    checks++;
    if (ct !== 3'd4) begin errors++; $display("FAIL rd_count: got %0d expected 4", ct); end
    checks++;
    if (n_rvalid !== 4) begin errors++; $display("FAIL rd_valid_pulses: got %0d expected 4", n_rvalid); end
    checks++;
  endtask

  task automatic test_disconnect();
    run_txn(4'b0111, 32'hFFFF0001, 3'd4);
    if (st !== 2'b01) begin errors++; $display("FAIL disc_status: got %b expected 01", st); end
    checks++;
    if (ct !== 3'd1) begin errors++; $display("FAIL disc_count: got %0d expected 1", ct); end
    checks++;
    if (n_stop !== 1) begin errors++; $display("FAIL disc_stopping: got %0d expected 1", n_stop); end
    checks++;
  endtask

  task automatic test_retry();
    run_txn(4'b0000, 32'hFFFF0001, 3'd4);
    if (st !== 2'b10) begin errors++; $display("FAIL retry_status: got %b expected 10", st); end
    checks++;
    if (ct !== 3'd0) begin errors++; $display("FAIL retry_count: got %0d expected 0", ct); end
    checks++;
  endtask

  task automatic test_master_abort();
    run_txn(4'b0110, 32'h12340000, 3'd4);
    if (st !== 2'b11) begin errors++; $display("FAIL abort_status: got %b expected 11", st); end
    checks++;
    if (ct !== 3'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", ct); end
    checks++;
    if (n_data !== 5) begin errors++; $display("FAIL abort_data_clocks: got %0d expected 5", n_data); end
    checks++;
    if (n_stop !== 1) begin errors++; $display("FAIL abort_frame_first: got %0d expected 1", n_stop); end
    checks++;
  endtask

  task automatic test_len_clamp();
    for (int i = 0; i < 4; i++) exp_rq.push_back(32'h0000F0F0 + 32'(i));
    run_txn(4'b0110, 32'hFFFF0000, 3'd7);
    if (ct !== 3'd4) begin errors++; $display("FAIL len7_count: got %0d expected 4", ct); end
    checks++;
    exp_rq.push_back(32'h0000F0F0);
    run_txn(4'b0110, 32'hFFFF0000, 3'd0);
    if (ct !== 3'd1) begin errors++; $display("FAIL len0_count: got %0d expected 1", ct); end
    checks++;
    if (exp_rq.size() != 0) begin
      errors++; $display("FAIL len_words_left: got %0d expected 0", exp_rq.size());
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h0000C0C0 + 32'(i);
    exp_wq.push_back(32'h0000C0C0);
    clear_counts();
    cmd = 4'b0111; addr = 32'hFFFF0000; len = 3'd4; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    if (frame !== 1'b1 || irdy !== 1'b1) begin
      errors++; $display("FAIL midrst_frame_irdy: got %b%b expected 11", frame, irdy);
    end
    checks++;
    if (cbe !== 4'hF || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_cbe_busy: got %h/%b expected f/0", cbe, busy);
    end
    checks++;
    repeat (3) @(negedge clk);
    if (n_done !== 0) begin errors++; $display("FAIL midrst_done: got %0d expected 0", n_done); end
    checks++;
    if (exp_wq.size() != 0) begin
      errors++; $display("FAIL midrst_words_left: got %0d expected 0", exp_wq.size());
    end
    checks++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // recovery: write then read back two words on the second target
    wbuf[0] = 32'h0000A5A0 + 32'($urandom_range(0, 255) << 16);
    wbuf[1] = 32'h0000A5A1 + 32'($urandom_range(0, 255) << 16);
    exp_wq.push_back(wbuf[0]); exp_wq.push_back(wbuf[1]);
    exp_rq.push_back(wbuf[0]); exp_rq.push_back(wbuf[1]);
    run_txn(4'b0111, 32'hFFFFF000, 3'd2);
    if (st !== 2'b00 || ct !== 3'd2) begin
      errors++; $display("FAIL recover_write: got %b/%0d expected 00/2", st, ct);
    end
    checks++;
    run_txn(4'b0110, 32'hFFFFF000, 3'd2);
    if (n_rvalid !== 2 || ct !== 3'd2) begin
      errors++; $display("FAIL recover_read: got %0d pulses/%0d expected 2/2", n_rvalid, ct);
    end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_write();
    test_read();
    test_disconnect();
    test_retry();
    test_master_abort();
    test_len_clamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
